// File: rtl/ps2_kbd_rx_if.sv
// Key-queue read port between the PS/2 receiver and the CPU bus read logic.
// Ports: rd_en from the consumer; rd_data/rd_ext/rd_brk give the head entry; empty/full/level give occupancy.
// The master modport is the receiver side. The slave modport is the consumer side.
interface ps2_kbd_rx_if #(
    parameter int LVL_W = 4
);
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_ext;
    logic             rd_brk;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;

    modport master (input rd_en, output rd_data, rd_ext, rd_brk, empty, full, level);
    modport slave  (output rd_en, input rd_data, rd_ext, rd_brk, empty, full, level);
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + glitch filter, start/parity/stop check, timeout, E0/F0 folding, FWFT key FIFO.
// Latency: error pulses 1 cycle after the stop-bit tick; the pushed entry is visible 2 cycles after it; a pop shows the next entry 1 cycle later.
// Backpressure: none toward the keyboard. A key arriving while the FIFO is full (and not popped that cycle) is dropped, and overflow is set.
// Ports: clk/rst; raw ps2_clk/ps2_data; rd_bus (rd_en, rd_data, rd_ext, rd_brk, empty, full, level); overflow, err_parity, err_frame.
module ps2_kbd_rx #(
    parameter int CLK_DIV       = 250,
    parameter int FILT_LEN      = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.master rd_bus,
    output logic         overflow,
    output logic         err_parity,
    output logic         err_frame
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

    // Two-flop synchronisers; reset to the idle-high line level.
    logic [1:0] clk_sync, dat_sync;
    logic       ps2_clk_s, ps2_data_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end
    assign ps2_clk_s  = clk_sync[1];
    assign ps2_data_s = dat_sync[1];

    // Sample tick.
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    assign tick = (tick_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + DIV_W'(1);
    end

    // Glitch filter. A falling edge is declared on the tick whose new history turns all-zero while the filtered clock is still high.
    logic [FILT_LEN-1:0] hist, hist_nxt;
    logic                filt_clk, fall;
    assign hist_nxt = {hist[FILT_LEN-2:0], ps2_clk_s};
    assign fall     = tick && filt_clk && (hist_nxt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist     <= '1;
            filt_clk <= 1'b1;
        end else if (tick) begin
            hist <= hist_nxt;
            if (&hist_nxt)            filt_clk <= 1'b1;
            else if (hist_nxt == '0)  filt_clk <= 1'b0;
        end
    end

    // Frame FSM. S_DATA collects eight data bits plus parity, LSB first, into the top of shreg.
    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      shreg_q, shreg_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_ok, par_bad, frm_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        to_cnt_d  = to_cnt_q;
        byte_ok   = 1'b0;
        par_bad   = 1'b0;
        frm_bad   = 1'b0;
        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                // A start bit sampled high is silently ignored.
                if (fall && !ps2_data_s) state_d = S_DATA;
            end
            S_DATA, S_STOP: begin
                if (fall) begin
                    to_cnt_d = '0;
                    if (state_q == S_DATA) begin
                        shreg_d   = {ps2_data_s, shreg_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd8) state_d = S_STOP;
                    end else begin
                        state_d = S_IDLE;
                        if (!ps2_data_s)    frm_bad = 1'b1;
                        else if (!(^shreg_q)) par_bad = 1'b1;
                        else                 byte_ok = 1'b1;
                    end
                end else if (tick) begin
                    if (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                        state_d = S_IDLE;
                        frm_bad = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic       byte_vld;
    logic [7:0] byte_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            byte_vld   <= 1'b0;
            byte_q     <= '0;
        end else begin
            err_parity <= par_bad;
            err_frame  <= frm_bad;
            byte_vld   <= byte_ok;
            if (byte_ok) byte_q <= shreg_q[7:0];
        end
    end

    // Prefix folding. Error frames never reach here, so they leave the pending flags intact.
    logic       ext_pend, brk_pend, push;
    logic [9:0] wdata;
    assign push  = byte_vld && (byte_q != 8'hE0) && (byte_q != 8'hF0);
    assign wdata = {ext_pend, brk_pend, byte_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (byte_vld) begin
            if (byte_q == 8'hE0)      ext_pend <= 1'b1;
            else if (byte_q == 8'hF0) brk_pend <= 1'b1;
            else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // FWFT FIFO. The head is kept in a register so it holds its last value once the FIFO drains.
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [LVL_W-1:0] count, cnt_nxt;
    logic [9:0]       head_q, head_nxt;
    logic             pop, push_ok, full_i;

    assign full_i     = (count == LVL_W'(FIFO_DEPTH));
    assign pop        = rd_bus.rd_en && (count != '0);
    assign push_ok    = push && (!full_i || pop);
    assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        cnt_nxt = count;
        if (push_ok && !pop)      cnt_nxt = count + LVL_W'(1);
        else if (!push_ok && pop) cnt_nxt = count - LVL_W'(1);
    end

    always_comb begin
        head_nxt = head_q;
        if (cnt_nxt != '0) begin
            // A push into the slot becoming head has not reached mem yet.
            if (push_ok && (rd_ptr_nxt == wr_ptr)) head_nxt = wdata;
            else                                   head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= cnt_nxt;
            head_q <= head_nxt;
            if (push && full_i && !pop) overflow <= 1'b1;
        end
    end

    assign rd_bus.rd_data = head_q[7:0];
    assign rd_bus.rd_brk  = head_q[8];
    assign rd_bus.rd_ext  = head_q[9];
    assign rd_bus.empty   = (count == '0);
    assign rd_bus.full    = full_i;
    assign rd_bus.level   = count;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: randomized PS/2 frames, a queue-based key model, and a monitor that pops and compares FIFO entries.
// Stimulus tasks push expected entries. The monitor drains the DUT independently whenever draining is enabled.
// Error pulses are counted per cycle and compared with the model's expected totals at checkpoints.
module tb_ps2_kbd_rx;
    localparam int CLK_DIV       = 4;
    localparam int FILT_LEN      = 2;
    localparam int FIFO_DEPTH    = 4;
    localparam int TIMEOUT_TICKS = 20;
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1;
    localparam int HALF          = 24;   // clk cycles per PS/2 half-bit

    logic clk = 1'b0;
    logic rst, ps2_clk, ps2_data, overflow, err_parity, err_frame;

    ps2_kbd_rx_if #(.LVL_W(LVL_W)) bus ();

    ps2_kbd_rx #(
        .CLK_DIV(CLK_DIV), .FILT_LEN(FILT_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_bus(bus), .overflow(overflow),
        .err_parity(err_parity), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];
    bit         m_ext = 0, m_brk = 0, m_ovf = 0;
    int         exp_par = 0, exp_frm = 0, got_par = 0, got_frm = 0;
    bit         drain = 0, pop_on_push = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the head whenever draining (or once, in the cycle a push lands) and compares against the model.
    initial begin
        bus.rd_en = 1'b0;
        forever begin
            @(negedge clk);
            bus.rd_en = 1'b0;
            if (!rst && !bus.empty && (drain || (pop_on_push && dut.push))) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got %0h, expected none", {bus.rd_ext, bus.rd_brk, bus.rd_data});
                end else begin
                    check("entry", {bus.rd_ext, bus.rd_brk, bus.rd_data}, exp_q.pop_front());
                end
                pop_on_push = 0;
                bus.rd_en   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (err_parity) got_par++;
            if (err_frame)  got_frm++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive the first nbits of an 11-bit frame; data changes while ps2_clk is high.
    task automatic ps2_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            idle(HALF);
            ps2_clk = 1'b0;
            idle(HALF);
            ps2_clk = 1'b1;
        end
        idle(HALF);
        ps2_data = 1'b1;
    endtask

    // Reference: error frames change only error totals; E0/F0 set pending flags; other bytes become entries.
    task automatic send_key(input logic [7:0] b, input bit flip_par, input bit bad_stop, input bit pop_same);
        if (bad_stop)          exp_frm++;
        else if (flip_par)     exp_par++;
        else if (b == 8'hE0)   m_ext = 1;
        else if (b == 8'hF0)   m_brk = 1;
        else begin
            if (exp_q.size() < FIFO_DEPTH || pop_same) exp_q.push_back({m_ext, m_brk, b});
            else                                      m_ovf = 1;
            m_ext = 0;
            m_brk = 0;
        end
        if (pop_same) pop_on_push = 1;
        ps2_frame(b, flip_par, bad_stop, 11);
        idle(2 * HALF);
    endtask

    function automatic logic [7:0] rand_key();
        logic [7:0] k;
        k = 8'($urandom_range(1, 8'hDF));
        return k;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_rd_data"}, bus.rd_data, 0);
        check({tag, "_rd_ext"}, bus.rd_ext, 0);
        check({tag, "_rd_brk"}, bus.rd_brk, 0);
        check({tag, "_empty"}, bus.empty, 1);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_level"}, bus.level, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_err_parity"}, err_parity, 0);
        check({tag, "_err_frame"}, err_frame, 0);
    endtask

    initial begin
        logic [7:0] b;
        int         r, e;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        idle(5);
        check_reset("reset");
        rst = 1'b0;
        idle(10);

        // Make code.
        send_key(8'h1C, 0, 0, 0);
        check("make_level", bus.level, 1);
        check("make_data", bus.rd_data, 8'h1C);
        check("make_flags", {bus.rd_ext, bus.rd_brk}, 2'b00);
        check("make_errs", got_par + got_frm, exp_par + exp_frm);
        drain = 1; idle(20);
        check("make_empty", bus.empty, 1);
        check("hold_data", bus.rd_data, 8'h1C);

        // Extended break.
        drain = 0;
        send_key(8'hE0, 0, 0, 0);
        send_key(8'hF0, 0, 0, 0);
        send_key(8'h75, 0, 0, 0);
        check("extbrk_level", bus.level, 1);
        check("extbrk_head", {bus.rd_ext, bus.rd_brk, bus.rd_data}, {2'b11, 8'h75});
        drain = 1; idle(20);

        // Bad parity, bad stop.
        send_key(8'h1C, 1, 0, 0);
        check("parity_err", got_par, exp_par);
        check("parity_level", bus.level, 0);
        send_key(8'h1C, 0, 1, 0);
        check("stop_err", got_frm, exp_frm);
        check("stop_level", bus.level, 0);

        // Timeout on a partial frame, then a good frame.
        ps2_frame(8'h55, 0, 0, 5);
        exp_frm++;
        idle((TIMEOUT_TICKS + 5) * CLK_DIV);
        check("timeout_err", got_frm, exp_frm);
        send_key(8'h29, 0, 0, 0);
        idle(20);
        check("after_timeout_drained", exp_q.size(), 0);
        check("after_timeout_errs", got_frm, exp_frm);

        // Overflow, including push with pop while full.
        drain = 0;
        for (int i = 0; i < FIFO_DEPTH; i++) send_key(rand_key(), 0, 0, 0);
        check("fill_full", bus.full, 1);
        check("fill_level", bus.level, FIFO_DEPTH);
        check("fill_overflow", overflow, 0);
        send_key(rand_key(), 0, 0, 1);
        check("pushpop_taken", pop_on_push, 0);
        check("pushpop_level", bus.level, FIFO_DEPTH);
        check("pushpop_overflow", overflow, m_ovf);
        send_key(rand_key(), 0, 0, 0);
        check("ovf_overflow", overflow, m_ovf);
        check("ovf_level", bus.level, FIFO_DEPTH);
        drain = 1; idle(20);
        check("ovf_empty", bus.empty, 1);
        check("ovf_drained", exp_q.size(), 0);

        // Random frames with prefixes and occasional errors.
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 9);
            b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : rand_key();
            e = $urandom_range(0, 9);
            send_key(b, e == 0, e == 1, 0);
        end
        idle(20);
        check("rand_par_errs", got_par, exp_par);
        check("rand_frm_errs", got_frm, exp_frm);
        check("rand_drained", exp_q.size(), 0);

        // One-tick glitch with data low: a captured start bit would later time out.
        ps2_data = 1'b0; idle(HALF);
        ps2_clk = 1'b0; idle(CLK_DIV);
        ps2_clk = 1'b1; idle((TIMEOUT_TICKS + 5) * CLK_DIV);
        ps2_data = 1'b1; idle(HALF);
        check("glitch_no_err", got_frm, exp_frm);
        send_key(8'h1C, 0, 0, 0);
        idle(20);
        check("glitch_drained", exp_q.size(), 0);

        // Reset mid-frame with a queued entry and an E0 pending.
        drain = 0;
        send_key(rand_key(), 0, 0, 0);
        send_key(8'hE0, 0, 0, 0);
        ps2_frame(8'h33, 0, 0, 5);
        rst = 1'b1;
        idle(3);
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0;
        check_reset("rst_mid");
        rst = 1'b0;
        idle(10);
        drain = 1;
        send_key(8'h1C, 0, 0, 0);
        idle(20);
        check("rst_drained", exp_q.size(), 0);
        check("rst_errs", got_par + got_frm, exp_par + exp_frm);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
